// File: rtl/alu_pkg.sv
// Shared encodings for alu_muldiv: RV func3/func7 values and the control FSM states.
package alu_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    // MUL's low half is sign-agnostic, so only the high-half and divide ops are signed.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension datapath: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, followed by a single fix-up cycle that applies signs and special cases.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            dz_q, dz_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            a_neg, b_neg;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign a_neg   = is_signed_a(op_i) & a_i[XLEN-1];
    assign b_neg   = is_signed_b(op_i) & b_i[XLEN-1];
    assign sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
    assign shifted = {hi_q, lo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, b_q};

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start_i) begin
            busy_d    = 1'b1;
            cnt_d     = CW'(XLEN);
            op_d      = op_i;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = (b_i == '0);
            b_d       = b_neg ? -b_i : b_i;
            hi_d      = '0;
            lo_d      = a_neg ? -a_i : a_i;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[2]) begin
                    // Restoring step: keep the trial subtraction only when it did not borrow.
                    if (!diff[XLEN]) begin
                        hi_d = diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = shifted[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Most-negative / -1 needs no special path: the magnitude quotient negates to itself.
    assign prod     = {hi_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot     = dz_q ? {XLEN{1'b1}} : (neg_q ? -lo_q : lo_q);
    assign rem      = rem_neg_q ? -hi_q : hi_q;
    assign done_o   = busy_q && (cnt_q == '0);

    always_comb begin
        result_o = '0;
        case (op_q)
            F3_MUL:                       result_o = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_o = quot;
            default:                      result_o = rem;
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execution unit: single-cycle RV base ops plus iterative M-extension ops,
// one operation in flight, result held in output registers until the consumer takes it.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter  int XLEN = 64,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [SHW-1:0]  shamt,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Comparison,
    output alu_state_e      dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the offering
    // side holds its payload stable until then, and out_valid/Result hold until out_ready.

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cmp_q, cmp_d;

    logic            accept;
    logic            is_m;
    logic            mdu_start;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;
    logic [XLEN-1:0] base_res;
    logic            base_cmp;
    logic [XLEN-1:0] sra_res;

    assign in_ready    = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept      = in_valid && in_ready;
    assign is_m        = (func7 == F7_MULDIV);
    assign out_valid   = (state_q == DONE);
    assign Result      = result_q;
    assign Comparison  = cmp_q;
    assign dbg_state_o = state_q;

    // Kept as its own net so the arithmetic shift is not turned logical by a mixed-sign mux.
    assign sra_res = $signed(A) >>> shamt;

    always_comb begin
        base_res = '0;
        base_cmp = 1'b0;
        case (func3)
            F3_ADD:  base_res = func7[5] ? (A - B) : (A + B);
            F3_SLL:  base_res = A << shamt;
            F3_SLT: begin
                base_cmp = ($signed(A) < $signed(B));
                base_res = {{(XLEN-1){1'b0}}, base_cmp};
            end
            F3_SLTU: begin
                base_cmp = (A < B);
                base_res = {{(XLEN-1){1'b0}}, base_cmp};
            end
            F3_XOR:  base_res = A ^ B;
            F3_SR: begin
                if (func7[5]) base_res = sra_res;
                else          base_res = A >> shamt;
            end
            F3_OR:   base_res = A | B;
            default: base_res = A & B;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cmp_d     = cmp_q;
        mdu_start = 1'b0;
        if (accept) begin
            if (is_m) begin
                mdu_start = 1'b1;
                state_d   = func3[2] ? DIV : MUL;
            end else begin
                state_d  = DONE;
                result_d = base_res;
                cmp_d    = base_cmp;
            end
        end else begin
            case (state_q)
                MUL, DIV: begin
                    if (mdu_done) begin
                        state_d  = DONE;
                        result_d = mdu_result;
                        cmp_d    = 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            cmp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
        end
    end

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mdu_start),
        .op_i    (func3),
        .a_i     (A),
        .b_i     (B),
        .done_o  (mdu_done),
        .result_o(mdu_result)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at XLEN=64 and XLEN=32 with queue-based result checking.
module tb_alu_muldiv;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid64, in_ready64, out_valid64, out_ready64, cmp64;
  logic [63:0] a64, b64, res64;
  logic [5:0]  sh64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;
  alu_state_e  st64;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, cmp32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  sh32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;
  alu_state_e  st32;

  alu_muldiv #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .A(a64), .B(b64), .shamt(sh64), .func3(f3_64), .func7(f7_64),
    .out_valid(out_valid64), .out_ready(out_ready64), .Result(res64),
    .Comparison(cmp64), .dbg_state_o(st64)
  );

  alu_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .shamt(sh32), .func3(f3_32), .func7(f7_32),
    .out_valid(out_valid32), .out_ready(out_ready32), .Result(res32),
    .Comparison(cmp32), .dbg_state_o(st32)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [64:0] exp64_q[$];
  logic [32:0] exp32_q[$];
  int          acc64, acc32;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor64();
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid64 && out_ready64) begin
        n_checks++;
        if (exp64_q.size() == 0) begin
          n_errors++;
          $display("FAIL mon64 unexpected: Result=%h with no pending op", res64);
        end else begin
          e = exp64_q.pop_front();
          if ({cmp64, res64} !== e) begin
            n_errors++;
            $display("FAIL mon64: Result=%h Comparison=%b, required Result=%h Comparison=%b",
                     res64, cmp64, e[63:0], e[64]);
          end
        end
      end
    end
  endtask

  task automatic monitor32();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid32 && out_ready32) begin
        n_checks++;
        if (exp32_q.size() == 0) begin
          n_errors++;
          $display("FAIL mon32 unexpected: Result=%h with no pending op", res32);
        end else begin
          e = exp32_q.pop_front();
          if ({cmp32, res32} !== e) begin
            n_errors++;
            $display("FAIL mon32: Result=%h Comparison=%b, required Result=%h Comparison=%b",
                     res32, cmp32, e[31:0], e[32]);
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
  task automatic drive64(input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                         input logic [2:0] f3, input logic [6:0] f7, input bit push,
                         input logic [63:0] er, input logic ec);
    int n = 0;
    if (push) exp64_q.push_back({ec, er});
    in_valid64 = 1'b1; a64 = a; b64 = b; sh64 = sh; f3_64 = f3; f7_64 = f7;
    @(negedge clk);
    while (!in_ready64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept64 in_ready", 64'(in_ready64), 64'd1);
    acc64 = cyc + 1;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
    sh64 = 6'($urandom);
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [2:0] f3, input logic [6:0] f7, input bit push,
                         input logic [31:0] er, input logic ec);
    int n = 0;
    if (push) exp32_q.push_back({ec, er});
    in_valid32 = 1'b1; a32 = a; b32 = b; sh32 = sh; f3_32 = f3; f7_32 = f7;
    @(negedge clk);
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept32 in_ready", 64'(in_ready32), 64'd1);
    acc32 = cyc + 1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    sh32 = 5'($urandom);
  endtask

  task automatic wait_valid64(input int lat, input string name);
    int n = 0;
    while (!out_valid64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(cyc - acc64), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid32(input int lat, input string name);
    int n = 0;
    while (!out_valid32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(cyc - acc32), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  task automatic mop64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input string name);
    drive64(a, b, 6'd0, f3, F7_MULDIV, 1'b1, er, 1'b0);
    wait_valid64(65, name);
  endtask

  task automatic mop32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input string name);
    drive32(a, b, 5'd0, f3, F7_MULDIV, 1'b1, er, 1'b0);
    wait_valid32(33, name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d n_errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc_add;
    int stale;
    rst_n = 1'b0;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; sh64 = '0; f3_64 = '0; f7_64 = '0; out_ready64 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sh32 = '0; f3_32 = '0; f7_32 = '0; out_ready32 = 1'b1;
    fork
      monitor64();
      monitor32();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check("rst out_valid64", 64'(out_valid64), 64'd0);
    check("rst Result64", res64, 64'd0);
    check("rst Comparison64", 64'(cmp64), 64'd0);
    check("rst in_ready64", 64'(in_ready64), 64'd0);
    check("rst state64", 64'(st64), 64'(IDLE));
    check("rst in_ready32", 64'(in_ready32), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD then SUB back-to-back
    drive64(64'd5, 64'd3, 6'd0, F3_ADD, F7_BASE, 1'b1, 64'd8, 1'b0);
    acc_add = acc64;
    check("add out_valid", 64'(out_valid64), 64'd1);
    drive64(64'd5, 64'd3, 6'd0, F3_ADD, F7_ALT, 1'b1, 64'd2, 1'b0);
    check("sub out_valid", 64'(out_valid64), 64'd1);
    check("sub accept cycle", 64'(acc64 - acc_add), 64'd1);
    @(posedge clk);
    #1;
    check("idle after drain", 64'(out_valid64), 64'd0);

    // Multiply
    mop64(F3_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
    mop64(F3_MUL, '1, '1, 64'd1, "mul");
    mop64(F3_MULH, '1, '1, 64'd0, "mulh");
    mop64(F3_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, "mulh minmin");
    mop64(F3_MULHSU, '1, 64'd2, '1, "mulhsu");

    // Divide
    mop64(F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div");
    mop64(F3_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, "rem");
    mop64(F3_DIVU, 64'd5, 64'd0, '1, "divu by 0");
    mop64(F3_REMU, 64'd5, 64'd0, 64'd5, "remu by 0");
    mop64(F3_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div ovf");
    mop64(F3_REM, 64'h8000_0000_0000_0000, '1, 64'd0, "rem ovf");
    mop64(F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, '1, "div by 0");
    mop64(F3_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, "rem by 0");
    mop64(F3_DIVU, 64'd100, 64'd7, 64'd14, "divu");
    mop64(F3_REMU, 64'd100, 64'd7, 64'd2, "remu");

    // SLTU held under back-pressure
    out_ready64 = 1'b0;
    drive64('1, 64'd1, 6'd0, F3_SLTU, F7_BASE, 1'b1, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", 64'(out_valid64), 64'd1);
      check("hold Result", res64, 64'd0);
      check("hold Comparison", 64'(cmp64), 64'd0);
      check("hold in_ready", 64'(in_ready64), 64'd0);
    end
    @(posedge clk);
    #1 out_ready64 = 1'b1;
    @(negedge clk);
    check("release in_ready", 64'(in_ready64), 64'd1);
    @(posedge clk);
    #1;
    check("released out_valid", 64'(out_valid64), 64'd0);

    drive64('1, 64'd1, 6'd0, F3_SLT, F7_BASE, 1'b1, 64'd1, 1'b1);
    @(posedge clk);
    #1;

    // XLEN=32 shifts, compare and M ops
    drive32(32'hF000_0000, 32'd3, 5'd4, F3_SR, F7_ALT, 1'b1, 32'hFF00_0000, 1'b0);
    drive32(32'hF000_0000, 32'd3, 5'd4, F3_SR, F7_BASE, 1'b1, 32'h0F00_0000, 1'b0);
    drive32(32'hFFFF_FFFF, 32'd1, 5'd0, F3_SLT, F7_BASE, 1'b1, 32'd1, 1'b1);
    @(posedge clk);
    #1;
    mop32(F3_MULHU, '1, '1, 32'hFFFF_FFFE, "mulhu32");
    mop32(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div32");

    // Reset in the middle of a DIV
    drive64(64'd100, 64'd7, 6'd0, F3_DIV, F7_MULDIV, 1'b0, 64'd0, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    check("div busy before reset", 64'(st64), 64'(DIV));
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst out_valid", 64'(out_valid64), 64'd0);
      check("midrst Result", res64, 64'd0);
      check("midrst in_ready", 64'(in_ready64), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready64", 64'(in_ready64), 64'd1);
    check("post-rst in_ready32", 64'(in_ready32), 64'd1);
    stale = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid64) stale++;
    end
    check("no stale result", 64'(stale), 64'd0);

    check("queue64 drained", 64'(exp64_q.size()), 64'd0);
    check("queue32 drained", 64'(exp32_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the combinational `alu`. It is a handshaked execution unit with width `XLEN`. It executes the RV base integer ops in one registered cycle and the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively. It sits between issue and writeback. Each side uses a valid/ready handshake, and one operation is in flight at a time.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 or 64.
- `SHW`, localparam `$clog2(XLEN)`: shift-amount width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: unit can accept this cycle.
- `A`, `B` input XLEN: operands.
- `shamt` input SHW: shift amount for SLL/SRL/SRA.
- `func3` input 3, `func7` input 7: operation select, RV encoding.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result.
- `Result` output XLEN: registered result.
- `Comparison` output 1: registered SLT/SLTU flag; 0 for all other ops.

## Operation
- Decode:
  - `func7 == 7'b0000001` selects M ops by `func3`: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Otherwise base ops by `func3`: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - `func7[5]` selects SUB (func3 000) and SRA (func3 101). It is ignored for the other base ops.
- SLT/SLTU: `Result = {XLEN-1 zeros, flag}`, `Comparison = flag`.
- Shifts use `shamt`, not `B`. ADD/SUB wrap modulo 2^XLEN.
- States:
  - IDLE: accepting. A base op moves to DONE; an M op loads operands and moves to MUL or DIV.
  - MUL: unsigned shift-add, one bit per cycle, on operand magnitudes; product is 2*XLEN bits.
  - DIV: unsigned restoring division, one bit per cycle, on operand magnitudes.
  - DONE: result held until `out_ready`.
- Step counter: starts at XLEN. The last step moves to DONE, applying sign fix-up and selecting the result half.
- Signed multiply: MULH treats both operands as signed. MULHSU treats A as signed and B as unsigned. The product is negated when the signs differ. MUL returns the low half; the MULH variants return the high half.
- Divide signs: the quotient is negative when the operand signs differ. The remainder takes the sign of A.
- Divide by zero: quotient is all-ones (DIV and DIVU); remainder is A.
- Signed overflow (most-negative divided by -1): quotient is A, remainder is 0.
- `in_ready = rst_n && (state == IDLE || (state == DONE && out_ready))`. This is a combinational path from `out_ready`.
- Accept happens when `in_valid && in_ready`. Operands are captured at that edge. Later input changes have no effect.

## Timing
- Reset: state IDLE, `out_valid = 0`, `Result = 0`, `Comparison = 0`, counter 0. `in_ready` is 0 while `rst_n` is low.
- Base op latency is 1: `out_valid` rises the cycle after accept. With `out_ready` held at 1, throughput is one op per cycle.
- M op latency is XLEN+1 cycles from the accept edge to `out_valid`, for every operand value including the special cases.
- `Result` and `Comparison` are stable while `out_valid && !out_ready`.
- DONE with `out_ready = 1` and an accepted `in_valid`: a base op goes to DONE again with the new result on the next cycle; an M op goes to MUL or DIV and `out_valid` drops.
- DONE with `out_ready = 1` and no new op: go to IDLE; `out_valid` drops next cycle.
- Reset asserted mid-MUL or mid-DIV aborts the operation. No result is ever presented for it.

## Structure
- `alu_pkg`: func3 constants, func7 constants (`F7_BASE`, `F7_ALT`, `F7_MULDIV`), and the state enum (IDLE, MUL, DIV, DONE).
- Sub-module `muldiv_iter`: iterative multiply/divide datapath covering counter, magnitude, fix-up and special-case logic, with a start/done interface.
- The top level holds the base ALU, decode, the FSM and the output registers.

## Test plan
All scenarios use XLEN=64 unless stated.
- Reset during a DIV at step 30: `out_valid = 0`, `Result = 0`, `in_ready = 0` while low; `in_ready = 1` the first cycle after release; no stale result appears.
- ADD 5+3 then SUB 5-3 back-to-back, `out_ready = 1`: `Result = 8` then `2` on consecutive cycles, `out_valid` continuously high.
- MULHU and MUL with A = B = 0xFFFF_FFFF_FFFF_FFFF: `Result = 0xFFFF_FFFF_FFFF_FFFE` and `1` respectively, `out_valid` exactly 65 cycles after accept. MULH of -1 × -1 gives 0.
- DIV -7/2 gives `0xFFFF_FFFF_FFFF_FFFD`; REM -7/2 gives `0xFFFF_FFFF_FFFF_FFFF`. DIVU 5/0 gives all-ones, REMU 5/0 gives 5. DIV 0x8000_0000_0000_0000 / -1 gives `0x8000_0000_0000_0000`, with REM 0.
- SLTU with A = all-ones, B = 1, and `out_ready = 0` for 5 cycles: `Result = 0` and `Comparison = 0` held stable, `in_ready = 0`. The result is released on the first `out_ready`.
- XLEN=32: SRA 0xF000_0000 by `shamt = 4` gives 0xFF00_0000. SRL gives 0x0F00_0000. SLT with -1 < 1 gives `Comparison = 1` and `Result = 1`.
